// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the fetch port (A) and the data port (B) onto one pmem
// interface. One transaction is outstanding at a time. B has priority, and a
// streak guard forces an A grant after STARVE_LIMIT consecutive B grants.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read_a,
    input  logic [15:0]          address_a,
    output logic                 resp_a,
    output logic [15:0]          rdata_a,
    input  logic                 read_b,
    input  logic                 write_b,
    input  logic [1:0]           wmask_b,
    input  logic [15:0]          address_b,
    input  logic [15:0]          wdata_b,
    output logic                 resp_b,
    output logic [15:0]          rdata_b,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [1:0]           pmem_wmask,
    output logic [15:0]          pmem_address,
    output logic [15:0]          pmem_wdata,
    input  logic                 pmem_resp,
    input  logic [15:0]          pmem_rdata,
    output logic [CNT_WIDTH-1:0] conflict_count,
    output logic [CNT_WIDTH-1:0] starve_count
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             streak_q, streak_d;
    logic [15:0]            addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [1:0]             wmask_q, wmask_d;
    logic                   is_write_q, is_write_d;
    logic [CNT_WIDTH-1:0]   conflict_q, conflict_d;
    logic [CNT_WIDTH-1:0]   starve_q, starve_d;

    logic req_a, req_b, force_a;

    assign req_a   = read_a;
    assign req_b   = read_b | write_b;
    assign force_a = req_a && (streak_q >= LIMIT);

    // Grant decision, request latching, streak and performance counters
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        is_write_d = is_write_q;
        conflict_d = conflict_q;
        starve_d   = starve_q;
        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    conflict_d = conflict_q + CNT_WIDTH'(1);
                end
                if (req_b && !force_a) begin
                    state_d    = BUSY_B;
                    addr_d     = address_b;
                    wdata_d    = wdata_b;
                    wmask_d    = wmask_b;
                    is_write_d = write_b;
                    if (req_a) begin
                        streak_d = (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end else if (req_a) begin
                    state_d  = BUSY_A;
                    addr_d   = address_a;
                    streak_d = 4'd0;
                    if (force_a) begin
                        starve_d = starve_q + CNT_WIDTH'(1);
                    end
                end
            end
            BUSY_A, BUSY_B: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // pmem drive and response pass-through, decoded from the current state only
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wmask   = 2'b00;
        pmem_address = 16'h0000;
        pmem_wdata   = 16'h0000;
        resp_a       = 1'b0;
        rdata_a      = 16'h0000;
        resp_b       = 1'b0;
        rdata_b      = 16'h0000;
        case (state_q)
            BUSY_A: begin
                pmem_read    = 1'b1;
                pmem_wmask   = 2'b11;
                pmem_address = addr_q;
                resp_a       = pmem_resp;
                rdata_a      = pmem_resp ? pmem_rdata : 16'h0000;
            end
            BUSY_B: begin
                pmem_read    = !is_write_q;
                pmem_write   = is_write_q;
                pmem_wmask   = wmask_q;
                pmem_address = addr_q;
                pmem_wdata   = wdata_q;
                resp_b       = pmem_resp;
                rdata_b      = pmem_resp ? pmem_rdata : 16'h0000;
            end
            default: ;
        endcase
    end

    assign conflict_count = conflict_q;
    assign starve_count   = starve_q;

    // State and latch registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            streak_q   <= 4'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            wmask_q    <= 2'b00;
            is_write_q <= 1'b0;
            conflict_q <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            is_write_q <= is_write_d;
            conflict_q <= conflict_d;
            starve_q   <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus, a transaction-level reference model checked
// every cycle, and literal expectations for the key scenarios.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk, rst;
    logic        read_a, read_b, write_b, pmem_resp;
    logic [15:0] address_a, address_b, wdata_b, pmem_rdata;
    logic [1:0]  wmask_b;
    logic        resp_a, resp_b, pmem_read, pmem_write;
    logic [15:0] rdata_a, rdata_b, pmem_address, pmem_wdata;
    logic [1:0]  pmem_wmask;
    logic [15:0] conflict_count, starve_count;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .conflict_count(conflict_count), .starve_count(starve_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns pmem, what was latched, grant history counters
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    logic [15:0] m_addr = 0, m_wdata = 0;
    logic [1:0]  m_wmask = 0;
    logic        m_wr = 0;
    int          m_streak = 0, m_conf = 0, m_starve = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= 0; m_streak <= 0; m_conf <= 0; m_starve <= 0;
            m_addr <= 0; m_wdata <= 0; m_wmask <= 0; m_wr <= 0;
        end else if (m_owner == 0) begin
            if (read_a && (read_b || write_b)) m_conf <= m_conf + 1;
            if ((read_b || write_b) && !(read_a && m_streak >= LIMIT)) begin
                m_owner <= 2; m_addr <= address_b; m_wdata <= wdata_b;
                m_wmask <= wmask_b; m_wr <= write_b;
                m_streak <= read_a ? ((m_streak >= 15) ? 15 : m_streak + 1) : 0;
            end else if (read_a) begin
                m_owner <= 1; m_addr <= address_a; m_streak <= 0;
                if (m_streak >= LIMIT) m_starve <= m_starve + 1;
            end
        end else if (pmem_resp) begin
            m_owner <= 0;
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pmem_read",  16'(pmem_read),  16'(m_owner == 1 || (m_owner == 2 && !m_wr)));
            chk("pmem_write", 16'(pmem_write), 16'(m_owner == 2 && m_wr));
            chk("resp_a", 16'(resp_a), 16'(m_owner == 1 && pmem_resp));
            chk("resp_b", 16'(resp_b), 16'(m_owner == 2 && pmem_resp));
            if (m_owner == 1 && pmem_resp) chk("rdata_a", rdata_a, pmem_rdata);
            if (m_owner == 2 && pmem_resp) chk("rdata_b", rdata_b, pmem_rdata);
            if (m_owner != 0) begin
                chk("pmem_address", pmem_address, m_addr);
                chk("pmem_wmask", 16'(pmem_wmask), (m_owner == 1) ? 16'h3 : 16'(m_wmask));
                chk("pmem_wdata", pmem_wdata, (m_owner == 1) ? 16'h0 : m_wdata);
            end
            chk("conflict_count", conflict_count, 16'(m_conf));
            chk("starve_count", starve_count, 16'(m_starve));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Wait for a pmem access, respond after lat cycles, report what was seen
    task automatic serve(input int lat, input logic [15:0] rd, input logic [1:0] clr,
                         output logic [15:0] addr, output logic [1:0] resp_seen,
                         output logic [15:0] rdata_seen);
        int n = 0;
        addr = 16'hxxxx; resp_seen = 2'b00; rdata_seen = 16'h0;
        while (!(pmem_read || pmem_write) && n < 20) begin
            tick(); n++;
        end
        if (n >= 20) begin
            vectors++; miscompares++;
            $display("FAIL serve_timeout: got no pmem access expected one within 20 cycles");
            return;
        end
        addr = pmem_address;
        repeat (lat - 1) tick();
        pmem_resp = 1'b1; pmem_rdata = rd;
        #1;
        resp_seen  = {resp_b, resp_a};
        rdata_seen = resp_a ? rdata_a : rdata_b;
        @(posedge clk); #1;
        pmem_resp = 1'b0; pmem_rdata = 16'h0;
        if (clr[0]) read_a = 1'b0;
        if (clr[1]) begin read_b = 1'b0; write_b = 1'b0; end
    endtask

    logic [15:0] a, rd;
    logic [1:0]  rs;
    logic [15:0] order [6];

    initial begin
        rst = 1'b1; read_a = 1'b1; read_b = 1'b1; write_b = 1'b0; wmask_b = 2'b11;
        address_a = 16'h1000; address_b = 16'h2000; wdata_b = 16'h0;
        pmem_resp = 1'b0; pmem_rdata = 16'h0;

        // Reset held two cycles with both requesters active
        tick(); chk_en = 1'b1;
        tick();
        chk("rst_outputs", {pmem_read, pmem_write, resp_a, resp_b, 12'h0}, 16'h0);
        chk("rst_addr", pmem_address, 16'h0);
        chk("rst_conflict", conflict_count, 16'h0);
        chk("rst_starve", starve_count, 16'h0);
        rst = 1'b0;
        serve(1, 16'h5555, 2'b10, a, rs, rd);
        chk("first_grant_b", a, 16'h2000);
        serve(1, 16'h6666, 2'b01, a, rs, rd);
        chk("then_grant_a", a, 16'h1000);

        // Single fetch with 3-cycle pmem latency
        read_a = 1'b1; address_a = 16'h3000;
        serve(3, 16'h1234, 2'b01, a, rs, rd);
        chk("fetch_addr", a, 16'h3000);
        chk("fetch_resp", 16'(rs), 16'h1);
        chk("fetch_rdata", rd, 16'h1234);

        // Data write; address changes mid-transaction must not leak through
        write_b = 1'b1; address_b = 16'h4001; wmask_b = 2'b10; wdata_b = 16'hAB00;
        tick();
        address_b = 16'h0000;
        tick();
        chk("wr_pmem_write", 16'(pmem_write), 16'h1);
        chk("wr_pmem_address", pmem_address, 16'h4001);
        chk("wr_pmem_wmask", 16'(pmem_wmask), 16'h2);
        chk("wr_pmem_wdata", pmem_wdata, 16'hAB00);
        pmem_resp = 1'b1; #1;
        chk("wr_resp_b", 16'(resp_b), 16'h1);
        tick();
        pmem_resp = 1'b0; write_b = 1'b0; wmask_b = 2'b11;

        // Stray pmem_resp while idle is ignored
        pmem_resp = 1'b1; #1;
        chk("idle_resp_ignored", {14'h0, resp_b, resp_a}, 16'h0);
        tick(); pmem_resp = 1'b0;

        // Conflict: B first, then A
        read_a = 1'b1; address_a = 16'h5000; read_b = 1'b1; address_b = 16'h6000;
        serve(2, 16'h0B0B, 2'b10, a, rs, rd);
        chk("conflict_first", a, 16'h6000);
        chk("conflict_first_resp", 16'(rs), 16'h2);
        serve(1, 16'h0A0A, 2'b01, a, rs, rd);
        chk("conflict_second", a, 16'h5000);
        chk("conflict_count", conflict_count, 16'd2);

        // Starvation: A held, B always requesting
        read_a = 1'b1; address_a = 16'hA000; read_b = 1'b1; address_b = 16'hB000;
        for (int i = 0; i < 6; i++) begin
            serve(1, 16'(i), (i == 5) ? 2'b11 : 2'b00, a, rs, rd);
            order[i] = a;
            if (i == 4) chk("starve_after_a", starve_count, 16'd1);
        end
        for (int i = 0; i < 6; i++)
            chk($sformatf("starve_order%0d", i), order[i], (i == 4) ? 16'hA000 : 16'hB000);
        chk("starve_conflicts", conflict_count, 16'd8);

        // Reset during the second pmem cycle of a data read
        read_b = 1'b1; address_b = 16'h7000;
        tick();
        tick();
        rst = 1'b1; read_b = 1'b0;
        tick();
        chk("midrst_pmem", {14'h0, pmem_read, pmem_write}, 16'h0);
        chk("midrst_resp_b", 16'(resp_b), 16'h0);
        chk("midrst_conflict", conflict_count, 16'h0);
        rst = 1'b0;
        read_a = 1'b1; address_a = 16'h8000;
        serve(2, 16'h4321, 2'b01, a, rs, rd);
        chk("post_rst_addr", a, 16'h8000);
        chk("post_rst_rdata", rd, 16'h4321);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the memory-stage datapath's port b (data) and the fetch stage's port a (instruction).
- Arbitrates both ports onto the single physical memory interface (pmem).
- One transaction is outstanding at a time. Data port has priority, with a starvation guard for the fetch port.
- Exports a conflict counter alongside the existing branch counters.

Parameters:
- STARVE_LIMIT, 4: consecutive B grants allowed while A is pending before A is forced; range 1..15.
- CNT_WIDTH, 16: width of performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- read_a  in  1  fetch read request
- address_a  in  16  fetch address
- resp_a  out  1  fetch response, one-cycle pulse
- rdata_a  out  16  fetch read data; valid only when resp_a=1
- read_b  in  1  data read request
- write_b  in  1  data write request
- wmask_b  in  2  data byte mask
- address_b  in  16  data address
- wdata_b  in  16  data write data
- resp_b  out  1  data response, one-cycle pulse
- rdata_b  out  16  data read data; valid only when resp_b=1
- pmem_read  out  1  physical memory read
- pmem_write  out  1  physical memory write
- pmem_wmask  out  2  physical byte mask
- pmem_address  out  16  physical address
- pmem_wdata  out  16  physical write data
- pmem_resp  in  1  physical memory done
- pmem_rdata  in  16  physical read data
- conflict_count  out  CNT_WIDTH  cycles in IDLE with both ports requesting
- starve_count  out  CNT_WIDTH  forced A grants due to STARVE_LIMIT

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk.
- Request definitions:
  - reqA = read_a.
  - reqB = read_b | write_b. read_b and write_b are never both high; if they are, treat the request as a write.
- States: IDLE, BUSY_A, BUSY_B.
- IDLE:
  - pmem_read, pmem_write, resp_a and resp_b are all 0.
  - reqB & !force_a: latch address_b, wdata_b, wmask_b and the is_write flag; go to BUSY_B.
  - Otherwise, if reqA: latch address_a; go to BUSY_A.
  - force_a = reqA & (streak >= STARVE_LIMIT).
- BUSY_A:
  - Drives pmem_read=1, pmem_address=latched address, pmem_wmask=2'b11, pmem_wdata=0.
  - When pmem_resp=1: resp_a=1 and rdata_a=pmem_rdata in the same cycle (combinational pass-through); next state IDLE.
- BUSY_B:
  - Drives pmem_read=!is_write, pmem_write=is_write, and the latched address, wdata and wmask.
  - When pmem_resp=1: resp_b=1 and rdata_b=pmem_rdata in the same cycle; next state IDLE.
- Latency:
  - Grant decision is made in IDLE; the first pmem cycle follows one cycle later.
  - Minimum request-to-resp time is 2 cycles, when pmem responds on its first cycle.
  - One mandatory IDLE cycle separates back-to-back transactions.
- Latching: requester inputs are sampled only on the grant edge. Changes to them during BUSY are ignored.
- Dropped request: if a requester deasserts mid-transaction, the transaction still completes and resp still pulses. The requester must ignore it.
- Streak counter, 4 bits:
  - On entering BUSY_B while reqA=1: streak increments, saturating at 15.
  - On entering BUSY_A: streak clears to 0.
  - On entering BUSY_B while reqA=0: streak clears to 0.
- conflict_count: increments each IDLE cycle with reqA & reqB; wraps modulo 2^CNT_WIDTH.
- starve_count: increments on each grant where force_a=1; wraps.
- The mux-to-pmem path, the pmem_resp to resp_a/resp_b path, and the pmem_rdata to rdata_a/rdata_b path are combinational from the state. No combinational path exists from the request inputs to the pmem outputs.
- Reset:
  - State goes to IDLE; streak=0; both counters=0; latched registers=0.
  - All outputs are 0 in the cycle after reset is sampled.
  - Reset mid-transaction abandons it: pmem_read/pmem_write drop the next cycle and no resp is issued. pmem tolerates a dropped request.
- pmem_resp arriving in IDLE is ignored.

Test Plan:
- Reset: hold rst 2 cycles with read_a=1 and read_b=1 -> all outputs 0, counters 0; first grant after release goes to B.
- Single fetch: read_a=1 @0x3000, pmem returns 0x1234 after 3 cycles -> pmem_read=1 with pmem_address=0x3000 from cycle 1; resp_a=1 and rdata_a=0x1234 for exactly one cycle; resp_b never asserted.
- Data write: write_b=1, address 0x4001, wmask 2'b10, wdata 0xAB00 -> pmem_write=1, pmem_wmask=2'b10, pmem_wdata=0xAB00; address_b changed to 0x0000 mid-transaction has no effect on pmem_address; resp_b pulses once.
- Conflict: read_a and read_b high together in IDLE -> B served first, A served after one IDLE cycle; conflict_count=1.
- Starvation with STARVE_LIMIT=4: read_a held high, read_b re-asserted every IDLE -> grant order B,B,B,B,A,B...; starve_count=1 after the A grant.
- Reset mid-BUSY_B: rst asserted on pmem cycle 2 -> next cycle pmem_read=0 and pmem_write=0, resp_b never pulses, state IDLE; a subsequent read_a completes normally.
